md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  one-cycle request from EX stage; qualifies md_op, rs_val and rt_val.
REQ-004 SHALL have port: md_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved.
REQ-005 SHALL have port: rs_val  input  32  first operand (forwarded rs).
REQ-006 SHALL have port: rt_val  input  32  second operand (forwarded rt).
REQ-007 SHALL have port: busy  output  1  high while a multiply/divide is in flight.
REQ-008 SHALL have port: hi  output  32  architectural HI register.
REQ-009 SHALL have port: lo  output  32  architectural LO register.
REQ-010 SHALL have parameter: MULT_LAT, default 5, busy cycles for MULT/MULTU.
REQ-011 SHALL have parameter: DIV_LAT, default 10, busy cycles for DIV/DIVU.

Function
REQ-012 SHALL implement states IDLE and RUN; busy = (state == RUN).
REQ-013 SHALL, in IDLE with start and md_op MULT/MULTU/DIV/DIVU, latch rs_val/rt_val/md_op, load a cycle counter with MULT_LAT or DIV_LAT, and enter RUN.
REQ-014 SHALL decrement the counter each RUN cycle; at the edge where it goes 1->0, write HI/LO and return to IDLE.
REQ-015 SHALL assert busy for exactly MULT_LAT (DIV_LAT) cycles after the start edge; the new HI/LO are visible in the first cycle busy is low.
REQ-016 SHALL keep hi/lo at their old values throughout RUN.
REQ-017 SHALL compute MULT as a signed 32x32->64 product and MULTU as an unsigned one; HI = bits 63:32, LO = bits 31:0.
REQ-018 SHALL compute DIV as a signed quotient truncated toward zero into LO and remainder into HI, with the remainder taking the sign of the dividend; DIVU unsigned.
REQ-019 SHALL, for DIV with 0x80000000 / 0xFFFFFFFF, produce LO = 0x80000000 and HI = 0.
REQ-020 SHALL, for DIV/DIVU with rt = 0, still run DIV_LAT busy cycles and leave HI and LO unchanged.
REQ-021 SHALL, in IDLE with start and MTHI (MTLO), write rs_val to HI (LO) at that edge, with no busy cycle.
REQ-022 SHALL ignore start while in RUN: no relatch, no counter reload, and no MTHI/MTLO write; the hazard unit stalls such instructions.
REQ-023 SHALL ignore start with a reserved md_op, making no state change.
REQ-024 SHALL use only the operands latched at start during RUN; input changes mid-operation SHALL NOT affect the result.

Reset
REQ-025 SHALL, on reset, force state to IDLE, counter to 0, busy to 0, hi to 0 and lo to 0 at the next edge.
REQ-026 SHALL let reset take priority over start and over a completing operation; a reset mid-RUN discards the result.

Structure
REQ-027 SHALL place the md_op encodings and the default MULT_LAT/DIV_LAT values in a shared package md_pkg.
REQ-028 SHALL place the combinational 64-bit product/quotient/remainder computation in one sub-module, md_calc; sequencing, counter and HI/LO registers stay in md_unit.

Verification
REQ-029 SHALL cover: MULT 0xFFFFFFFE * 3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; the same operands with MULTU give HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 SHALL cover: DIV -8 / 3 -> busy 10 cycles, then LO=0xFFFFFFFE, HI=0xFFFFFFFE; DIVU 8 / 3 gives LO=2, HI=2.
REQ-031 SHALL cover: MTHI 0x12345678 in IDLE -> hi=0x12345678 the next cycle with busy staying 0; MTLO issued during RUN has no effect.
REQ-032 SHALL cover: DIV by 0 with HI=0xAAAA0000, LO=0x0000BBBB preloaded -> busy 10 cycles, HI/LO unchanged.
REQ-033 SHALL cover: reset asserted in the 3rd busy cycle of a MULT -> busy=0, hi=lo=0 next cycle, and the result is never written.
REQ-034 SHALL cover: a second MULT start during RUN, then operand changes -> only the first operation completes, after exactly 5 busy cycles, with its latched operands.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op_e      : md_op encodings (MULT, MULTU, DIV, DIVU, MTHI, MTLO, reserved)
//   md_state_e   : sequencer states
//   MULT_LAT_DEF : default busy cycles for MULT/MULTU
//   DIV_LAT_DEF  : default busy cycles for DIV/DIVU
package md_pkg;

   typedef enum logic [2:0] {
      OpMult  = 3'b000,
      OpMultu = 3'b001,
      OpDiv   = 3'b010,
      OpDivu  = 3'b011,
      OpMthi  = 3'b100,
      OpMtlo  = 3'b101,
      OpRsv6  = 3'b110,
      OpRsv7  = 3'b111
   } md_op_e;

   typedef enum logic {
      StIdle,
      StRun
   } md_state_e;

   localparam int unsigned MULT_LAT_DEF = 5;
   localparam int unsigned DIV_LAT_DEF  = 10;

   // Multiply/divide ops occupy the lower half of the encoding space.
   function automatic logic is_muldiv(md_op_e op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic is_div(md_op_e op);
      return (op == OpDiv) || (op == OpDivu);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//   start  : one-cycle request, qualifies md_op/rs_val/rt_val
//   md_op  : operation select
//   rs_val : first operand
//   rt_val : second operand
//   busy   : multiply/divide in flight
//   hi, lo : architectural HI/LO registers
// master = EX stage side, slave = md_unit side.
interface md_unit_if;
   import md_pkg::*;

   logic        start;
   md_op_e      md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start,
      output md_op,
      output rs_val,
      output rt_val,
      input  busy,
      input  hi,
      input  lo
   );

   modport slave (
      input  start,
      input  md_op,
      input  rs_val,
      input  rt_val,
      output busy,
      output hi,
      output lo
   );

endinterface

// File: rtl/md_calc.sv
// Combinational 64-bit product / quotient / remainder for the latched operation.
//   op     : latched md_op
//   a, b   : latched rs/rt operands
//   hi, lo : result halves (product 63:32 / 31:0, or remainder / quotient)
//   wr_en  : result is architecturally valid (low for divide by zero and non-arith ops)
module md_calc
   import md_pkg::*;
(
   input  md_op_e      op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        wr_en
);

   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_u;
   logic [31:0] r_u;
   logic        b_zero;

   always_comb begin
      // Sign- or zero-extend to 64 bits; the low 64 bits of the 64x64 product
      // are then the exact signed or unsigned 32x32 product.
      if (op == OpMult) begin
         a_ext = {{32{a[31]}}, a};
         b_ext = {{32{b[31]}}, b};
      end else begin
         a_ext = {32'd0, a};
         b_ext = {32'd0, b};
      end
      prod = a_ext * b_ext;

      b_zero = (b == 32'd0);

      // Signed divide via magnitudes. 0x80000000 / -1 falls out naturally as
      // q = 0x80000000, r = 0 after truncation to 32 bits.
      a_mag = a[31] ? (32'd0 - a) : a;
      b_mag = b[31] ? (32'd0 - b) : b;
      q_mag = b_zero ? 32'd0 : (a_mag / b_mag);
      r_mag = b_zero ? 32'd0 : (a_mag % b_mag);
      q_u   = b_zero ? 32'd0 : (a / b);
      r_u   = b_zero ? 32'd0 : (a % b);

      hi    = 32'd0;
      lo    = 32'd0;
      wr_en = 1'b0;
      case (op)
         OpMult, OpMultu: begin
            hi    = prod[63:32];
            lo    = prod[31:0];
            wr_en = 1'b1;
         end
         OpDiv: begin
            lo    = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
            hi    = a[31] ? (32'd0 - r_mag) : r_mag;
            wr_en = !b_zero;
         end
         OpDivu: begin
            lo    = q_u;
            hi    = r_u;
            wr_en = !b_zero;
         end
         default: begin
            wr_en = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
//   clk   : sole clock, rising edge
//   reset : synchronous active-high reset
//   bus   : md_unit_if slave (start/md_op/rs_val/rt_val in, busy/hi/lo out)
// MULT/MULTU hold busy for MULT_LAT cycles and DIV/DIVU for DIV_LAT cycles,
// then update HI/LO. MTHI/MTLO write in the start cycle. Requests while busy
// are ignored; the hazard unit is expected to stall them.
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned MULT_LAT = MULT_LAT_DEF,
   parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave bus
);

   localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);

   md_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   md_op_e        op_q, op_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;

   logic [31:0]   calc_hi;
   logic [31:0]   calc_lo;
   logic          calc_wr_en;
   logic          accept;
   logic          finish;

   assign accept = (state_q == StIdle) && bus.start && is_muldiv(bus.md_op);
   assign finish = (state_q == StRun) && (cnt_q == CntW'(1));

   md_calc u_calc (
      .op    (op_q),
      .a     (a_q),
      .b     (b_q),
      .hi    (calc_hi),
      .lo    (calc_lo),
      .wr_en (calc_wr_en)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StRun;
         StRun:   if (finish) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs.
   always_comb begin
      bus.busy = (state_q == StRun);
      bus.hi   = hi_q;
      bus.lo   = lo_q;
   end

   // Datapath next-state: counter, operand latches, HI/LO.
   always_comb begin
      cnt_d = cnt_q;
      op_d  = op_q;
      a_d   = a_q;
      b_d   = b_q;
      hi_d  = hi_q;
      lo_d  = lo_q;

      if (state_q == StIdle) begin
         if (accept) begin
            op_d  = bus.md_op;
            a_d   = bus.rs_val;
            b_d   = bus.rt_val;
            cnt_d = is_div(bus.md_op) ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
         end else if (bus.start && (bus.md_op == OpMthi)) begin
            hi_d = bus.rs_val;
         end else if (bus.start && (bus.md_op == OpMtlo)) begin
            lo_d = bus.rs_val;
         end
      end else begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
         end
         // Divide by zero still burns the full latency but leaves HI/LO alone.
         if (finish && calc_wr_en) begin
            hi_d = calc_hi;
            lo_d = calc_lo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         hi_q  <= 32'd0;
         lo_q  <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

   // Operand latches need no reset: they are only consumed in StRun.
   always_ff @(posedge clk) begin
      op_q <= op_d;
      a_q  <= a_d;
      b_q  <= b_d;
   end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
   import md_pkg::*;

   localparam int unsigned MultLat = 5;
   localparam int unsigned DivLat  = 10;

   logic clk = 1'b0;
   logic reset;

   int vecs = 0;
   int errs = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   md_unit_if bus ();

   md_unit #(
      .MULT_LAT (MultLat),
      .DIV_LAT  (DivLat)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic busy_exp);
      chk({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, busy_exp});
      chk({tag, "_hi"}, bus.hi, m_hi);
      chk({tag, "_lo"}, bus.lo, m_lo);
   endtask

   function automatic md_op_e rand_op();
      logic [2:0] v;
      v = 3'($urandom_range(0, 7));
      return md_op_e'(v);
   endfunction

   // Reference: result as {hi, lo} straight from integer arithmetic.
   function automatic logic [63:0] ref_calc(input md_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
      int              sa;
      int              sb;
      longint          la;
      longint          lb;
      longint unsigned ua;
      longint unsigned ub;
      logic [63:0]     q;
      logic [63:0]     r;
      sa = a;
      sb = b;
      la = sa;
      lb = sb;
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OpMult:  return la * lb;
         OpMultu: return ua * ub;
         OpDiv: begin
            q = la / lb;
            r = la % lb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            q = ua / ub;
            r = ua % ub;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   // Issue a mul/div, optionally hammering start/operands while busy.
   task automatic do_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input string tag);
      int unsigned lat;
      logic [63:0] res;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      bit          is_d;
      is_d   = (op == OpDiv) || (op == OpDivu);
      lat    = is_d ? DivLat : MultLat;
      exp_hi = m_hi;
      exp_lo = m_lo;
      if (!(is_d && b == 32'd0)) begin
         res    = ref_calc(op, a, b);
         exp_hi = res[63:32];
         exp_lo = res[31:0];
      end
      bus.start  = 1'b1;
      bus.md_op  = op;
      bus.rs_val = a;
      bus.rt_val = b;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < int'(lat); i++) begin
         chk_all({tag, "_run"}, 1'b1);
         bus.rs_val = $urandom;
         bus.rt_val = $urandom;
         if (disturb) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.md_op = rand_op();
         end
         step();
      end
      bus.start = 1'b0;
      m_hi = exp_hi;
      m_lo = exp_lo;
      chk_all({tag, "_done"}, 1'b0);
   endtask

   // Single-cycle request: MTHI/MTLO write, reserved ops do nothing.
   task automatic do_mt(input md_op_e op, input logic [31:0] v, input string tag);
      bus.start  = 1'b1;
      bus.md_op  = op;
      bus.rs_val = v;
      bus.rt_val = $urandom;
      step();
      bus.start = 1'b0;
      if (op == OpMthi) m_hi = v;
      if (op == OpMtlo) m_lo = v;
      chk_all(tag, 1'b0);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.md_op  = OpMult;
      bus.rs_val = 32'd0;
      bus.rt_val = 32'd0;
      reset      = 1'b1;
      m_hi       = 32'd0;
      m_lo       = 32'd0;
      step();
      step();
      chk_all("reset", 1'b0);
      reset = 1'b0;
      step();
      chk_all("post_reset", 1'b0);

      do_op(OpMult, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult");
      chk("mult_hi_lit", bus.hi, 32'hFFFF_FFFF);
      chk("mult_lo_lit", bus.lo, 32'hFFFF_FFFA);
      do_op(OpMultu, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu");
      chk("multu_hi_lit", bus.hi, 32'h0000_0002);
      chk("multu_lo_lit", bus.lo, 32'hFFFF_FFFA);

      do_op(OpDiv, 32'hFFFF_FFF8, 32'd3, 1'b0, "div");
      chk("div_hi_lit", bus.hi, 32'hFFFF_FFFE);
      chk("div_lo_lit", bus.lo, 32'hFFFF_FFFE);
      do_op(OpDivu, 32'd8, 32'd3, 1'b0, "divu");
      chk("divu_hi_lit", bus.hi, 32'd2);
      chk("divu_lo_lit", bus.lo, 32'd2);

      do_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
      chk("div_ovf_hi_lit", bus.hi, 32'd0);
      chk("div_ovf_lo_lit", bus.lo, 32'h8000_0000);

      do_mt(OpMthi, 32'h1234_5678, "mthi");
      chk("mthi_lit", bus.hi, 32'h1234_5678);

      // MTLO while busy must be ignored.
      bus.start  = 1'b1;
      bus.md_op  = OpMultu;
      bus.rs_val = 32'd7;
      bus.rt_val = 32'd6;
      step();
      bus.md_op  = OpMtlo;
      bus.rs_val = 32'hDEAD_BEEF;
      step();
      bus.start = 1'b0;
      chk_all("mtlo_in_run", 1'b1);
      for (int i = 0; i < int'(MultLat) - 1; i++) step();
      m_hi = 32'd0;
      m_lo = 32'd42;
      chk_all("mtlo_in_run_done", 1'b0);

      // Divide by zero with preloaded HI/LO.
      do_mt(OpMthi, 32'hAAAA_0000, "pre_hi");
      do_mt(OpMtlo, 32'h0000_BBBB, "pre_lo");
      do_op(OpDiv, 32'h0000_1234, 32'd0, 1'b0, "div0");
      chk("div0_hi_lit", bus.hi, 32'hAAAA_0000);
      chk("div0_lo_lit", bus.lo, 32'h0000_BBBB);
      do_op(OpDivu, 32'hFFFF_0000, 32'd0, 1'b1, "divu0");

      // Reset in the third busy cycle of a MULT discards the result.
      bus.start  = 1'b1;
      bus.md_op  = OpMult;
      bus.rs_val = 32'd1000;
      bus.rt_val = 32'd1000;
      step();
      bus.start = 1'b0;
      step();
      step();
      chk("rst_mid_busy", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      chk_all("rst_mid", 1'b0);
      for (int i = 0; i < int'(MultLat) + 2; i++) begin
         step();
         chk_all("rst_mid_after", 1'b0);
      end

      // Second start and operand churn while busy.
      do_op(OpMult, 32'h0001_0003, 32'hFFFF_0005, 1'b1, "mult_restart");

      // Reserved encodings.
      do_mt(OpRsv6, 32'h5555_5555, "rsv6");
      do_mt(OpRsv7, 32'h6666_6666, "rsv7");

      // Random sequence.
      for (int n = 0; n < 30; n++) begin
         md_op_e      op;
         logic [31:0] a;
         logic [31:0] b;
         op = rand_op();
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 16));
         if (op == OpMthi || op == OpMtlo || op == OpRsv6 || op == OpRsv7) begin
            do_mt(op, a, "rnd_mt");
         end else begin
            do_op(op, a, b, 1'($urandom_range(0, 1)), "rnd_op");
         end
         if ($urandom_range(0, 2) == 0) begin
            step();
            chk_all("rnd_idle", 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
